// File: rtl/des_pkg.sv
// Shared DES constants and helpers: permutation tables, S-boxes, the
// decrypt rotation schedule, the FSM state type and bit-mapping helpers.
// All vectors put DES bit 1 at the MSB.
package des_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} des_state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box: 64 nibbles in reading order (row 0 col 0 at the MSB).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Right-rotation applied to C/D before decrypt rounds 1..16.
  localparam logic [1:0] ROT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Vector index of 1-based DES bit pos inside a width-bit field.
  function automatic int unsigned des_bit(input int unsigned width, input int unsigned pos);
    return width - pos;
  endfunction

  function automatic logic take_bit(input logic [63:0] x, input int unsigned width,
                                    input int unsigned pos);
    return 1'(x >> des_bit(width, pos));
  endfunction

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++) r = {r[62:0], take_bit(x, 64, IP_T[i])};
    return r;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++) r = {r[62:0], take_bit(x, 64, FP_T[i])};
    return r;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] r = '0;
    for (int i = 0; i < 56; i++) r = {r[54:0], take_bit(x, 64, PC1_T[i])};
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] r = '0;
    for (int i = 0; i < 48; i++) r = {r[46:0], take_bit(64'(x), 56, PC2_T[i])};
    return r;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] r = '0;
    for (int i = 0; i < 48; i++) r = {r[46:0], take_bit(64'(x), 32, E_T[i])};
    return r;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r = {r[30:0], take_bit(64'(x), 32, P_T[i])};
    return r;
  endfunction

  // Row is the outer bit pair, column the middle four bits.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] x);
    logic [5:0] pos;
    pos = 6'd63 - {x[5], x[0], x[4:1]};
    return 4'(SBOX[box] >> {pos, 2'b00});
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Set when any key byte carries even parity.
  function automatic logic key_parity_err(input logic [63:0] key);
    logic e = 1'b0;
    for (int b = 0; b < 8; b++) e = e | ~(^(8'(key >> (8 * b))));
    return e;
  endfunction

endpackage

// File: rtl/des_feistel_round.sv
// Single combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_feistel_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic [31:0] o_l,
  output logic [31:0] o_r
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  // Expansion, key mixing and the eight S-box substitutions.
  always_comb begin
    w_x = e_expand(i_r) ^ i_subkey;
    w_s = '0;
    for (int b = 0; b < 8; b++) begin
      w_s = {w_s[27:0], sbox_lookup(3'(b), 6'(w_x >> (42 - 6 * b)))};
    end
  end

  assign o_l = i_r;
  assign o_r = i_l ^ p_perm(w_s);

endmodule

// File: rtl/des_key_sched_dec.sv
// Decrypt key schedule: holds C/D, rotates them right by the per-round
// amount and presents PC2 of the rotated halves as the round subkey.
module des_key_sched_dec
  import des_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [63:0] i_key,
  input  logic [3:0]  i_round,
  output logic [47:0] o_subkey
);

  logic [27:0] r_c, r_d;
  logic [27:0] w_c_rot, w_d_rot;

  // The rotation for the current round is applied before PC2, so round 1
  // (rotation 0) sees PC1(key) directly, which is K16.
  always_comb begin
    w_c_rot = rotr28(r_c, ROT_DEC[i_round]);
    w_d_rot = rotr28(r_d, ROT_DEC[i_round]);
  end

  assign o_subkey = pc2_perm({w_c_rot, w_d_rot});

  // C/D load on accept and advance once per round.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c <= '0;
      r_d <= '0;
    end else if (i_load) begin
      {r_c, r_d} <= pc1_perm(i_key);
    end else if (i_step) begin
      r_c <= w_c_rot;
      r_d <= w_d_rot;
    end
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core, one Feistel round per clock, subkeys
// K16..K1 generated on the fly. Optional key parity flag under the
// DES_KEY_PARITY_EN macro.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] ct_i,
  input  logic [63:0] key_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] pt_o
`ifdef DES_KEY_PARITY_EN
  ,
  output logic        key_par_err_o
`endif
);

  des_state_e  r_state, w_state_next;
  logic [3:0]  r_round;
  logic [31:0] r_l, r_r, w_l_next, w_r_next;
  logic [47:0] w_subkey;
  logic [63:0] r_pt;
  logic        w_accept, w_run, w_last;

  // Next state and handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_state_next = r_state;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_round == 4'd15) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  des_key_sched_dec u_key_sched (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_load   (w_accept),
    .i_step   (w_run),
    .i_key    (key_i),
    .i_round  (r_round),
    .o_subkey (w_subkey)
  );

  des_feistel_round u_round (
    .i_l      (r_l),
    .i_r      (r_r),
    .i_subkey (w_subkey),
    .o_l      (w_l_next),
    .o_r      (w_r_next)
  );

  // L/R halves, round counter and registered plaintext (halves swapped before FP).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_l     <= '0;
      r_r     <= '0;
      r_round <= '0;
      r_pt    <= '0;
    end else begin
      if (w_accept) begin
        {r_l, r_r} <= ip_perm(ct_i);
        r_round    <= '0;
      end else if (w_run) begin
        r_l     <= w_l_next;
        r_r     <= w_r_next;
        r_round <= r_round + 4'd1;
      end
      if (w_last) r_pt <= fp_perm({w_r_next, w_l_next});
    end
  end

  assign pt_o = r_pt;

`ifdef DES_KEY_PARITY_EN
  logic r_key_par_err;

  // Parity of the key as presented at accept, held with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_key_par_err <= 1'b0;
    else if (w_accept) r_key_par_err <= key_parity_err(key_i);
  end

  assign key_par_err_o = r_key_par_err;
`endif

endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative DES decryption core. It takes one 64-bit ciphertext block and a 64-bit key through a valid/ready input handshake and computes one Feistel round per clock. The round subkeys are applied in reverse order (K16..K1) and generated on the fly. The 64-bit plaintext is presented through a valid/ready output handshake. It is the inverse-direction counterpart of the single-round Feistel datapath and sits beside the encryption path in the DES subsystem.

## Interface
- No parameters; all widths are fixed by FIPS 46-3.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  ciphertext/key offered
- in_ready_o  output  1  core idle and able to accept
- ct_i  input  64  ciphertext; bit 63 is DES bit 1
- key_i  input  64  key including parity bits; bit 63 is DES bit 1
- out_valid_o  output  1  plaintext available
- out_ready_i  input  1  consumer takes plaintext
- pt_o  output  64  plaintext; bit 63 is DES bit 1
- key_par_err_o  output  1  key parity error flag; present only with DES_KEY_PARITY_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: latch L/R = IP(ct_i) and C/D = PC1(key_i), clear round counter, go to RUN.
- RUN
  - in_ready_o=0. Each cycle performs one round: L' = R, R' = L ^ f(R, PC2(C,D)).
  - Decrypt round r (1..16) uses C/D rotated right by the cumulative amount. Before rounds 1..16 the per-round right-rotation amounts are 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Because the encryption rotations total 28, round 1 uses PC2(PC1(key)) directly.
  - 4-bit round counter 0..15. After round 16: load pt_o = FP({R16, L16}) (halves swapped), go to DONE.
- DONE
  - out_valid_o=1, with pt_o held stable.
  - On out_valid_o & out_ready_i: go to IDLE.
  - in_ready_o stays 0 until IDLE, so no new block is accepted in the handshake cycle.
- Inputs are sampled only at the accepting edge. Changes to ct_i/key_i afterwards have no effect.
- Key parity bits (DES bits 8,16,…,64) are dropped by PC1 and never affect pt_o.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE and counter=0. L, R, C, D and pt_o are cleared to 0. out_valid_o=0, in_ready_o=1 (1 during reset assertion). key_par_err_o=0. Any in-flight block is lost without notice.

## Timing
- Input accepted at edge N. Rounds 1..16 occur at edges N+1..N+16, with the output registered at N+16.
- out_valid_o is high from the cycle after edge N+16, so latency is 16 cycles from accept to valid.
- out_ready_i held high: DONE lasts 1 cycle, then 1 IDLE cycle, so the minimum block period is 18 cycles.
- Backpressure: out_valid_o and pt_o hold indefinitely while out_ready_i=0. out_valid_o must not drop without a handshake.
- pt_o is a registered output. The round logic is combinational between the L/R/C/D registers and must close in one cycle.

## Configuration
- DES_KEY_PARITY_EN
  - Defined: key_par_err_o exists. At accept, compute whether any key_i byte has even parity and register that result. The flag is driven with pt_o, is valid while out_valid_o=1, and resets to 0. Decryption proceeds regardless of the flag.
  - Undefined: the port and its logic are absent, and parity bits are silently ignored.

## Structure
- Package des_pkg holds:
  - Permutation tables as constants: IP, FP, PC1, PC2, E, P.
  - The S-box contents.
  - The decrypt rotation schedule constant: 16 entries of 2 bits.
  - The FSM state enum typedef.
  - Helper functions for the 1-based DES bit-index mapping.
- Sub-module des_key_sched_dec holds the C/D registers.
  - Load: PC1.
  - Step: right rotation per schedule, indexed by the round counter.
  - Output: 48-bit subkey PC2(C,D).
- The round datapath reuses the team's existing single-round Feistel module unchanged.

## Test plan
- Known answer: key 133457799BBCDFF1, ct 85E813540F0AB405, out_ready_i=1 → plaintext 0123456789ABCDEF. out_valid_o rises exactly 16 cycles after accept.
- Second vector: key 0E329232EA6D0D73, ct 0000000000000000 → plaintext 8787878787878787. Send it back-to-back with the first vector; the second accept occurs no earlier than 18 cycles after the first.
- Backpressure: hold out_ready_i=0 for 10 cycles after valid. pt_o and out_valid_o remain stable, in_ready_o=0 throughout, and the handshake completes on the first out_ready_i=1.
- Reset in RUN: assert rst_ni low at round 7 → in_ready_o=1, out_valid_o=0, pt_o=0 immediately. A fresh block after release decrypts correctly.
- Input stability: after accept, change ct_i/key_i every cycle → result is unchanged (0123456789ABCDEF for vector 1).
- DES_KEY_PARITY_EN: key 133457799BBCDFF0 with ct 85E813540F0AB405 → pt_o 0123456789ABCDEF and key_par_err_o=1. Key 133457799BBCDFF1 → key_par_err_o=0.
